tinker_io_port: RTL
===================

Name: tinker_io_port

Overview:
- Device-side responder for the CPU's `in`/`out` instruction ports.
- Output side: captures words the CPU emits (`out_signal`/`out_data`) into an output FIFO and drains them to a host consumer over a valid/ready stream.
- Input side: buffers host-supplied words in an input FIFO, presents the head word to the CPU's `in_data`, and pops it when the CPU asserts `in_signal`.
- Sits beside `cpu` in the top level, between the CPU I/O pins and the testbench/host.

Parameters:
- WIDTH, 64, data word width.
- DEPTH, 16, entries per FIFO; power of two, minimum 2.
- EDGE_MODE, 1
  - 1: a CPU strobe counts once, on its rising edge.
  - 0: every cycle the strobe is high counts as one transfer.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- cpu_in_signal  input  1  CPU read strobe; consumes the word on cpu_in_data.
- cpu_in_data  output  WIDTH  head of input FIFO; 0 when empty.
- cpu_out_signal  input  1  CPU write strobe.
- cpu_out_data  input  WIDTH  word written by CPU.
- host_in_valid  input  1  host offers a word.
- host_in_ready  output  1  input FIFO can accept.
- host_in_data  input  WIDTH  host word.
- host_out_valid  output  1  output FIFO non-empty.
- host_out_ready  input  1  host accepts the head word.
- host_out_data  output  WIDTH  output FIFO head; 0 when empty.
- in_count  output  $clog2(DEPTH)+1  input FIFO occupancy.
- out_count  output  $clog2(DEPTH)+1  output FIFO occupancy.
- in_underflow  output  1  sticky: CPU read while input FIFO empty.
- out_overflow  output  1  sticky: CPU write while output FIFO full.
- clear_errors  input  1  clears both sticky flags.

Behaviour:
- Reset (synchronous, active-high):
  - Pointers, counts, in_underflow and out_overflow go to 0.
  - Edge-detect history registers go to 0.
  - FIFO storage contents are don't-care and are discarded.
  - Reset mid-operation drops all buffered words.
  - Outputs in the cycle after reset: host_in_ready=1, host_out_valid=0, cpu_in_data=0, host_out_data=0.
- Strobe qualification:
  - EDGE_MODE=1: rd_evt = cpu_in_signal & ~prev_in; wr_evt = cpu_out_signal & ~prev_out.
  - prev_in/prev_out are registered copies of the strobes.
  - A strobe already high in the first cycle after reset counts as an edge.
  - EDGE_MODE=0: each event equals its strobe level.
- FIFOs: both are first-word-fall-through circular buffers of DEPTH entries.
  - Pointers are $clog2(DEPTH) bits, wrap modulo DEPTH, with a separate occupancy counter.
  - full = (count == DEPTH); empty = (count == 0).
- Input FIFO:
  - Push when host_in_valid & host_in_ready.
  - host_in_ready = ~full, based on pre-cycle state; no same-cycle pop credit.
  - Pop when rd_evt & ~empty.
  - cpu_in_data is combinational from the head entry, forced to 0 when empty.
  - A pushed word is visible on cpu_in_data one cycle after the push edge.
  - rd_evt while empty: in_underflow <= 1; pointers and count unchanged; cpu_in_data stays 0.
- Output FIFO:
  - Push when wr_evt & ~full, using the pre-cycle full; cpu_out_data is sampled on that edge.
  - wr_evt while full: the word is dropped and out_overflow <= 1, even if the host pops in the same cycle.
  - Pop when host_out_valid & host_out_ready.
  - host_out_valid = ~empty; host_out_data is combinational from the head entry, 0 when empty.
- Simultaneous push and pop on one FIFO: both occur and the count is unchanged. When empty, a same-cycle push does not satisfy the pop.
- Sticky flags:
  - Set on an error event; cleared by clear_errors.
  - If set and clear occur in the same cycle, set wins.
- Counts update on the clock edge following the event.
- No combinational path from cpu_* inputs to host_* outputs, or the reverse.
- Latency:
  - CPU write to host_out_valid: 1 cycle.
  - Host push to cpu_in_data: 1 cycle.

Test Plan:
- Reset then idle 5 cycles -> host_in_ready=1, host_out_valid=0, in_count=0, out_count=0, cpu_in_data=0, no flags set.
- CPU pulses cpu_out_signal with 0x1234, 0xDEAD, 0xBEEF, host_out_ready=0; then host_out_ready=1 -> out_count reaches 3; host receives 0x1234, 0xDEAD, 0xBEEF in order; out_count returns to 0.
- EDGE_MODE=1, cpu_out_signal held high 10 cycles with cpu_out_data=7 -> exactly one word (7) captured; out_count=1.
- Host pushes 17 words 1..17 with DEPTH=16 and no CPU reads -> host_in_ready drops after word 16; in_count=16; word 17 held by host; cpu_in_data=1.
- Input FIFO empty, CPU pulses cpu_in_signal -> in_underflow=1, cpu_in_data=0, in_count=0; clear_errors pulse -> in_underflow=0.
- Output FIFO full (16 words): CPU writes 0x99 in the same cycle host pops -> word dropped, out_overflow=1, out_count=15, then reset asserted mid-drain -> out_count=0, host_out_valid=0, out_overflow=0.

Source files
------------

// File: rtl/tinker_io_port_if.sv
// Bundle of CPU in/out strobes and host valid/ready streams for tinker_io_port.
// The master side is the CPU/host environment; the slave side is the port device.
interface tinker_io_port_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             cpu_in_signal;
  logic [WIDTH-1:0] cpu_in_data;
  logic             cpu_out_signal;
  logic [WIDTH-1:0] cpu_out_data;
  logic             host_in_valid;
  logic             host_in_ready;
  logic [WIDTH-1:0] host_in_data;
  logic             host_out_valid;
  logic             host_out_ready;
  logic [WIDTH-1:0] host_out_data;
  logic [CW-1:0]    in_count;
  logic [CW-1:0]    out_count;
  logic             in_underflow;
  logic             out_overflow;
  logic             clear_errors;

  modport master (
    output cpu_in_signal, cpu_out_signal, cpu_out_data,
    output host_in_valid, host_in_data, host_out_ready, clear_errors,
    input  cpu_in_data, host_in_ready, host_out_valid, host_out_data,
    input  in_count, out_count, in_underflow, out_overflow
  );

  modport slave (
    input  cpu_in_signal, cpu_out_signal, cpu_out_data,
    input  host_in_valid, host_in_data, host_out_ready, clear_errors,
    output cpu_in_data, host_in_ready, host_out_valid, host_out_data,
    output in_count, out_count, in_underflow, out_overflow
  );
endinterface

// File: rtl/tinker_io_port.sv
// CPU in/out port responder: host->CPU input FIFO and CPU->host output FIFO,
// both first-word-fall-through, with sticky underflow/overflow flags.
module tinker_io_port #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 16,
  parameter int EDGE_MODE = 1
) (
  input  logic          clk,
  input  logic          reset,
  tinker_io_port_if.slave io
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // bit 0: CPU read strobe, bit 1: CPU write strobe
  logic [1:0] strobe;
  logic [1:0] prev_reg;
  logic [1:0] evt;
  logic       rd_evt;
  logic       wr_evt;

  assign strobe = {io.cpu_out_signal, io.cpu_in_signal};
  assign evt    = (EDGE_MODE != 0) ? (strobe & ~prev_reg) : strobe;
  assign rd_evt = evt[0];
  assign wr_evt = evt[1];

  always_ff @(posedge clk) begin
    if (reset) prev_reg <= '0;
    else       prev_reg <= strobe;
  end

  logic [WIDTH-1:0] in_mem [DEPTH];
  logic [AW-1:0]    in_wr_ptr_reg, in_rd_ptr_reg;
  logic [CW-1:0]    in_count_reg;
  logic             in_full, in_empty, in_push, in_pop;

  logic [WIDTH-1:0] out_mem [DEPTH];
  logic [AW-1:0]    out_wr_ptr_reg, out_rd_ptr_reg;
  logic [CW-1:0]    out_count_reg;
  logic             out_full, out_empty, out_push, out_pop;

  logic             in_underflow_reg, out_overflow_reg;

  // All handshake decisions use the pre-cycle occupancy; a pop never frees
  // room for a push in the same cycle and a push never feeds a same-cycle pop.
  assign in_full   = (in_count_reg == FULL_COUNT);
  assign in_empty  = (in_count_reg == '0);
  assign in_push   = io.host_in_valid & ~in_full;
  assign in_pop    = rd_evt & ~in_empty;

  assign out_full  = (out_count_reg == FULL_COUNT);
  assign out_empty = (out_count_reg == '0);
  assign out_push  = wr_evt & ~out_full;
  assign out_pop   = io.host_out_ready & ~out_empty;

  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wr_ptr_reg]   <= io.host_in_data;
    if (out_push) out_mem[out_wr_ptr_reg] <= io.cpu_out_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_wr_ptr_reg  <= '0;
      in_rd_ptr_reg  <= '0;
      in_count_reg   <= '0;
      out_wr_ptr_reg <= '0;
      out_rd_ptr_reg <= '0;
      out_count_reg  <= '0;
    end else begin
      if (in_push)  in_wr_ptr_reg  <= in_wr_ptr_reg + AW'(1);
      if (in_pop)   in_rd_ptr_reg  <= in_rd_ptr_reg + AW'(1);
      if (out_push) out_wr_ptr_reg <= out_wr_ptr_reg + AW'(1);
      if (out_pop)  out_rd_ptr_reg <= out_rd_ptr_reg + AW'(1);
      in_count_reg  <= in_count_reg + CW'(in_push) - CW'(in_pop);
      out_count_reg <= out_count_reg + CW'(out_push) - CW'(out_pop);
    end
  end

  // A new error event outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_underflow_reg <= 1'b0;
      out_overflow_reg <= 1'b0;
    end else begin
      in_underflow_reg <= (rd_evt & in_empty) | (in_underflow_reg & ~io.clear_errors);
      out_overflow_reg <= (wr_evt & out_full) | (out_overflow_reg & ~io.clear_errors);
    end
  end

  assign io.host_in_ready  = ~in_full;
  assign io.cpu_in_data    = in_empty ? '0 : in_mem[in_rd_ptr_reg];
  assign io.host_out_valid = ~out_empty;
  assign io.host_out_data  = out_empty ? '0 : out_mem[out_rd_ptr_reg];
  assign io.in_count       = in_count_reg;
  assign io.out_count      = out_count_reg;
  assign io.in_underflow   = in_underflow_reg;
  assign io.out_overflow   = out_overflow_reg;
endmodule
